// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate helpers.
// Used by the timing generator and by the pattern generators (screen centre).
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Raw timing figures, in pixel clocks (horizontal) and lines (vertical).
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = 800;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = 525;

  // 10-bit decode points, so every compare against a coordinate is width-matched.
  localparam coord_t H_ACT_END    = 10'(H_ACTIVE);
  localparam coord_t H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_MAX        = 10'(H_TOTAL - 1);

  localparam coord_t V_ACT_END    = 10'(V_ACTIVE);
  localparam coord_t V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_MAX        = 10'(V_TOTAL - 1);

  // Screen centre for the pattern generators.
  localparam coord_t X_CENTRE = 10'(H_ACTIVE / 2);
  localparam coord_t Y_CENTRE = 10'(V_ACTIVE / 2);

  // True when lo <= val < hi.
  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter 0..Max that wraps to 0; wrap_o flags the incrementing cycle at Max.
// Used for both the horizontal and vertical VGA counters.
module wrap_counter #(
  parameter int unsigned       Width = 10,
  parameter logic [Width-1:0]  Max   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: hold unless incrementing, return to zero after Max.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = (count_q == Max) ? '0 : count_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Output view of the count and the wrap strobe.
  always_comb begin
    count_o = count_q;
    wrap_o  = inc_i && (count_q == Max);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator: h/v counters, sync/active decode, frame strobe.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame counter output frame_cnt_o.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       active_o,
  output logic       next_frame_o
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt_o
`endif
);

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;

  wrap_counter #(
    .Width (10),
    .Max   (H_MAX)
  ) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ena_i),
    .count_o (h_count),
    .wrap_o  (h_wrap)
  );

  // Vertical counter steps only on the enabled clock where the line wraps.
  wrap_counter #(
    .Width (10),
    .Max   (V_MAX)
  ) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (h_wrap),
    .count_o (v_count),
    .wrap_o  (v_wrap)
  );

  // Combinational decode of the counter registers; no output pipeline.
  always_comb begin
    x_o          = h_count;
    y_o          = v_count;
    hsync_o      = !in_window(h_count, H_SYNC_START, H_SYNC_END);
    vsync_o      = !in_window(v_count, V_SYNC_START, V_SYNC_END);
    active_o     = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    // Gated by ena so a stall on (0,480) drops the strobe and it fires only once.
    next_frame_o = ena_i && (v_count == V_ACT_END) && (h_count == '0);
  end

  // A frame can only end on the last pixel of a line.
  frame_wrap_on_line_end: assert property (
    @(posedge clk) disable iff (rst) v_wrap |-> (h_count == H_MAX)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Advance once per frame strobe, wrapping naturally at 8 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (next_frame_o) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
